// File: rtl/nco_est_pkg.sv
`timescale 1ns/1ps
// Shared constants for the NCO phase estimator: default widths, CORDIC gain
// and the arctangent table scaled to NCO accumulator units.
package nco_est_pkg;

    localparam int MPR_DEF   = 14;
    localparam int PW_DEF    = 16;
    localparam int NITER_DEF = 14;

    // Magnitude growth of a full CORDIC vectoring run.
    localparam real CORDIC_GAIN = 1.6467602581210654;

    function automatic int xw(input int mpr);
        return mpr + 2;
    endfunction

    // round(atan(2^-i) * 2^pw / (2*pi)), derived from a 32-bit reference table.
    function automatic logic [31:0] atan_lsb(input int i, input int pw);
        logic [63:0] a;
        case (i)
            0:       a = 64'h2000_0000;
            1:       a = 64'h12E4_051E;
            2:       a = 64'h09FB_385B;
            3:       a = 64'h0511_11D4;
            4:       a = 64'h028B_0D43;
            5:       a = 64'h0145_D7E1;
            6:       a = 64'h00A2_F61E;
            7:       a = 64'h0051_7C55;
            8:       a = 64'h0028_BE53;
            9:       a = 64'h0014_5F2F;
            10:      a = 64'h000A_2F98;
            11:      a = 64'h0005_17CC;
            12:      a = 64'h0002_8BE6;
            13:      a = 64'h0001_45F3;
            14:      a = 64'h0000_A2FA;
            default: a = 64'h0000_517D >> (i - 15);
        endcase
        if (pw < 32) begin
            a = (a + (64'd1 << (31 - pw))) >> (32 - pw);
        end
        return a[31:0];
    endfunction

endpackage

// File: rtl/nco_est_cordic_stage.sv
`timescale 1ns/1ps
// One registered CORDIC vectoring micro-rotation: drives y toward zero while
// accumulating the rotated angle in z.
module nco_est_cordic_stage
    import nco_est_pkg::*;
#(
    parameter int   MPR   = MPR_DEF,
    parameter int   PW    = PW_DEF,
    parameter int   SHIFT = 0,
    localparam int  XW    = xw(MPR)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 clken,
    input  logic                 valid_i,
    input  logic                 zero_i,
    input  logic signed [XW-1:0] x_i,
    input  logic signed [XW-1:0] y_i,
    input  logic        [PW-1:0] z_i,
    output logic                 valid_o,
    output logic                 zero_o,
    output logic signed [XW-1:0] x_o,
    output logic signed [XW-1:0] y_o,
    output logic        [PW-1:0] z_o
);

    localparam logic [PW-1:0] ANGLE = PW'(atan_lsb(SHIFT, PW));

    logic                 valid_q, valid_d;
    logic                 zero_q, zero_d;
    logic signed [XW-1:0] x_q, x_d;
    logic signed [XW-1:0] y_q, y_d;
    logic        [PW-1:0] z_q, z_d;

    always_comb begin
        // NOTE: every _d gets a default first, so no path can infer a latch.
        valid_d = valid_q;
        zero_d  = zero_q;
        x_d     = x_q;
        y_d     = y_q;
        z_d     = z_q;
        if (clken) begin
            valid_d = valid_i;
            zero_d  = zero_i;
            if (!y_i[XW-1]) begin
                x_d = x_i + (y_i >>> SHIFT);
                y_d = y_i - (x_i >>> SHIFT);
                z_d = z_i + ANGLE;
            end else begin
                x_d = x_i - (y_i >>> SHIFT);
                y_d = y_i + (x_i >>> SHIFT);
                z_d = z_i - ANGLE;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments; all of them reset,
    // since the valid bit alone cannot mask stale data on a mid-stream reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= 1'b0;
            zero_q  <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
        end else begin
            valid_q <= valid_d;
            zero_q  <= zero_d;
            x_q     <= x_d;
            y_q     <= y_d;
            z_q     <= z_d;
        end
    end

    assign valid_o = valid_q;
    assign zero_o  = zero_q;
    assign x_o     = x_q;
    assign y_o     = y_q;
    assign z_o     = z_q;

endmodule

// File: rtl/nco_phase_est.sv
`timescale 1ns/1ps
// Pipelined I/Q phase, phase-increment and magnitude estimator: quadrant
// pre-rotation, NITER CORDIC vectoring stages, then a differencing output stage.
module nco_phase_est
    import nco_est_pkg::*;
#(
    parameter int MPR   = MPR_DEF,
    parameter int PW    = PW_DEF,
    parameter int NITER = NITER_DEF
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  clken,
    input  logic                  in_valid,
    input  logic signed [MPR-1:0] fsin_i,
    input  logic signed [MPR-1:0] fcos_i,
    output logic        [PW-1:0]  phase_o,
    output logic        [PW-1:0]  phi_inc_o,
    output logic        [MPR:0]   mag_o,
    output logic                  out_valid,
    output logic                  inc_valid
);

    localparam int            XW        = xw(MPR);
    localparam logic [PW-1:0] HALF_TURN = PW'(1) << (PW - 1);

    logic                 valid_s [NITER+1];
    logic                 zero_s  [NITER+1];
    logic signed [XW-1:0] x_s     [NITER+1];
    logic signed [XW-1:0] y_s     [NITER+1];
    logic        [PW-1:0] z_s     [NITER+1];

    logic signed [XW-1:0] cos_x, sin_x;
    logic                 p_valid_q, p_valid_d, p_zero_q, p_zero_d;
    logic signed [XW-1:0] px_q, px_d, py_q, py_d;
    logic        [PW-1:0] pz_q, pz_d;

    assign cos_x = {{(XW-MPR){fcos_i[MPR-1]}}, fcos_i};
    assign sin_x = {{(XW-MPR){fsin_i[MPR-1]}}, fsin_i};

    // Left half-plane vectors are rotated by pi so the CORDIC only sees x >= 0.
    always_comb begin
        p_valid_d = p_valid_q;
        p_zero_d  = p_zero_q;
        px_d      = px_q;
        py_d      = py_q;
        pz_d      = pz_q;
        if (clken) begin
            p_valid_d = in_valid;
            p_zero_d  = (fsin_i == '0) && (fcos_i == '0);
            if (fcos_i[MPR-1]) begin
                px_d = -cos_x;
                py_d = -sin_x;
                pz_d = HALF_TURN;
            end else begin
                px_d = cos_x;
                py_d = sin_x;
                pz_d = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            p_valid_q <= 1'b0;
            p_zero_q  <= 1'b0;
            px_q      <= '0;
            py_q      <= '0;
            pz_q      <= '0;
        end else begin
            p_valid_q <= p_valid_d;
            p_zero_q  <= p_zero_d;
            px_q      <= px_d;
            py_q      <= py_d;
            pz_q      <= pz_d;
        end
    end

    assign valid_s[0] = p_valid_q;
    assign zero_s[0]  = p_zero_q;
    assign x_s[0]     = px_q;
    assign y_s[0]     = py_q;
    assign z_s[0]     = pz_q;

    for (genvar g = 0; g < NITER; g++) begin : g_stage
        nco_est_cordic_stage #(
            .MPR   (MPR),
            .PW    (PW),
            .SHIFT (g)
        ) u_stage (
            .clk     (clk),
            .reset_n (reset_n),
            .clken   (clken),
            .valid_i (valid_s[g]),
            .zero_i  (zero_s[g]),
            .x_i     (x_s[g]),
            .y_i     (y_s[g]),
            .z_i     (z_s[g]),
            .valid_o (valid_s[g+1]),
            .zero_o  (zero_s[g+1]),
            .x_o     (x_s[g+1]),
            .y_o     (y_s[g+1]),
            .z_o     (z_s[g+1])
        );
    end

    // Residual y and the sign/guard bits of x carry no output information.
    logic unused_bits;
    assign unused_bits = ^{y_s[NITER], x_s[NITER][XW-1:MPR+1]};

    logic [PW-1:0] phase_new;
    logic [MPR:0]  mag_new;
    logic [PW-1:0] phase_q, phase_d, inc_q, inc_d;
    logic [MPR:0]  mag_q, mag_d;
    logic          out_valid_q, out_valid_d, inc_valid_q, inc_valid_d;
    logic          have_prev_q, have_prev_d;

    assign phase_new = zero_s[NITER] ? '0 : z_s[NITER];
    assign mag_new   = zero_s[NITER] ? '0 : x_s[NITER][MPR:0];

    // phase_q only moves on valid outputs, so it doubles as the previous phase.
    always_comb begin
        phase_d     = phase_q;
        mag_d       = mag_q;
        inc_d       = inc_q;
        out_valid_d = out_valid_q;
        inc_valid_d = inc_valid_q;
        have_prev_d = have_prev_q;
        if (clken) begin
            out_valid_d = valid_s[NITER];
            inc_valid_d = valid_s[NITER] && have_prev_q;
            if (valid_s[NITER]) begin
                phase_d     = phase_new;
                mag_d       = mag_new;
                inc_d       = phase_new - phase_q;
                have_prev_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phase_q     <= '0;
            mag_q       <= '0;
            inc_q       <= '0;
            out_valid_q <= 1'b0;
            inc_valid_q <= 1'b0;
            have_prev_q <= 1'b0;
        end else begin
            phase_q     <= phase_d;
            mag_q       <= mag_d;
            inc_q       <= inc_d;
            out_valid_q <= out_valid_d;
            inc_valid_q <= inc_valid_d;
            have_prev_q <= have_prev_d;
        end
    end

    assign phase_o   = phase_q;
    assign phi_inc_o = inc_q;
    assign mag_o     = mag_q;
    assign out_valid = out_valid_q;
    assign inc_valid = inc_valid_q;

endmodule

// File: tb/tb_nco_phase_est.sv
`timescale 1ns/1ps
// Directed bench for nco_phase_est: reset state, axis points, latency, NCO
// loopback, wrap-around, zero input, clock-enable gating and mid-stream reset.
module tb_nco_phase_est;
    import nco_est_pkg::*;

    localparam int MPR = 14;
    localparam int PW  = 16;
    localparam int LAT = NITER_DEF + 2;
    localparam int NS  = 20;
    localparam int NR  = NS + LAT;

    logic                  clk = 1'b0;
    logic                  reset_n, clken, in_valid;
    logic signed [MPR-1:0] fsin_i, fcos_i;
    logic        [PW-1:0]  phase_o, phi_inc_o;
    logic        [MPR:0]   mag_o;
    logic                  out_valid, inc_valid;

    int n_assert = 0;
    int n_fail   = 0;

    logic        stim_v [NS];
    int          stim_c [NS];
    int          stim_s [NS];
    logic [63:0] ref_snap [NR];
    int          pat [5] = '{1, 0, 1, 1, 0};
    logic [15:0] wph [4] = '{16'hFF00, 16'h0100, 16'h0100, 16'hFF00};

    nco_phase_est dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .clken     (clken),
        .in_valid  (in_valid),
        .fsin_i    (fsin_i),
        .fcos_i    (fcos_i),
        .phase_o   (phase_o),
        .phi_inc_o (phi_inc_o),
        .mag_o     (mag_o),
        .out_valid (out_valid),
        .inc_valid (inc_valid)
    );

    always #5 clk = ~clk;

    function automatic int rnd(input real r);
        return (r >= 0.0) ? $rtoi(r + 0.5) : $rtoi(r - 0.5);
    endfunction

    function automatic logic [63:0] snap();
        return 64'({out_valid, inc_valid, phase_o, phi_inc_o, mag_o});
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic v, input int c, input int s);
        in_valid = v;
        fcos_i   = MPR'(c);
        fsin_i   = MPR'(s);
    endtask

    task automatic put_phase(input logic [15:0] ph);
        real a;
        a = 6.283185307179586 * real'(ph) / 65536.0;
        put(1'b1, rnd(8191.0 * $cos(a)), rnd(8191.0 * $sin(a)));
    endtask

    task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Modular distance check for phase-like 16-bit quantities.
    task automatic chk_near(input string tag, input logic [15:0] obs, input logic [15:0] exp,
                            input int tol);
        logic signed [15:0] d;
        int                 di;
        d  = obs - exp;
        di = d;
        n_assert++;
        assert (di >= -tol && di <= tol) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h +/-%0d", tag, obs, exp, tol);
        end
    endtask

    task automatic pulse_reset();
        put(1'b0, 0, 0);
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
    endtask

    // Single isolated sample: out_valid must rise exactly LAT enabled cycles later.
    task automatic run_point(input string tag, input int c, input int s,
                             input logic [15:0] exp_ph, input logic exp_iv,
                             input logic [15:0] exp_inc);
        put(1'b1, c, s);
        step();
        put(1'b0, 0, 0);
        repeat (LAT - 2) step();
        chk_eq({tag, "_early"}, 64'(out_valid), 64'd0);
        step();
        chk_eq({tag, "_ov"}, 64'(out_valid), 64'd1);
        chk_near({tag, "_ph"}, phase_o, exp_ph, 4);
        chk_eq({tag, "_iv"}, 64'(inc_valid), 64'(exp_iv));
        if (exp_iv) chk_near({tag, "_inc"}, phi_inc_o, exp_inc, 8);
    endtask

    initial begin
        logic [63:0] prev;
        logic        stale;
        int          e;
        int          c;

        reset_n = 1'b0;
        clken   = 1'b1;
        put(1'b0, 0, 0);
        step();
        step();
        chk_eq("rst_phase", 64'(phase_o), 64'd0);
        chk_eq("rst_inc", 64'(phi_inc_o), 64'd0);
        chk_eq("rst_mag", 64'(mag_o), 64'd0);
        chk_eq("rst_ov", 64'(out_valid), 64'd0);
        chk_eq("rst_iv", 64'(inc_valid), 64'd0);
        reset_n = 1'b1;
        step();

        // Axis points; each increment is about a quarter turn from the previous one.
        run_point("ax0", 8191, 0, 16'h0000, 1'b0, 16'h0000);
        // Truncating shifts bias the magnitude a few LSB above gain*8191.
        chk_near("ax0_mag", 16'(mag_o), 16'(rnd(8191.0 * CORDIC_GAIN)), 6);
        run_point("ax90", 0, 8191, 16'h4000, 1'b1, 16'h4000);
        run_point("ax180", -8192, 0, 16'h8000, 1'b1, 16'h4000);
        run_point("ax270", 0, -8192, 16'hC000, 1'b1, 16'h4000);

        // Zero vector forces 0/0; the following increment is referenced to phase 0.
        run_point("zero", 0, 0, 16'h0000, 1'b1, 16'h4000);
        chk_eq("zero_ph_exact", 64'(phase_o), 64'd0);
        chk_eq("zero_mag", 64'(mag_o), 64'd0);
        run_point("after_zero", 0, 8191, 16'h4000, 1'b1, 16'h4000);

        // NCO loopback with a 0x0400 phase step, continuous valid.
        pulse_reset();
        for (int t = 0; t < 24 + LAT; t++) begin
            if (t < 24) put_phase(16'(t * 16'h0400));
            else put(1'b0, 0, 0);
            step();
            if (t >= LAT - 1 && t - (LAT - 1) < 24) begin
                chk_eq($sformatf("lb_ov%0d", t - (LAT - 1)), 64'(out_valid), 64'd1);
                chk_eq($sformatf("lb_iv%0d", t - (LAT - 1)), 64'(inc_valid),
                       64'(t != LAT - 1));
                if (t != LAT - 1)
                    chk_near($sformatf("lb_inc%0d", t - (LAT - 1)), phi_inc_o, 16'h0400, 8);
            end
        end

        // Wrap-around across 2*pi in both directions.
        for (int t = 0; t < 4 + LAT; t++) begin
            if (t < 4) put_phase(wph[t]);
            else put(1'b0, 0, 0);
            step();
            if (t == LAT) chk_near("wrap_up", phi_inc_o, 16'h0200, 8);
            if (t == LAT + 2) chk_near("wrap_down", phi_inc_o, 16'hFE00, 8);
        end

        // Clock-enable gating: the compressed gated run must match a clken=1 run.
        for (int i = 0; i < NS; i++) begin
            stim_v[i] = 1'($urandom_range(0, 1));
            stim_c[i] = int'($urandom_range(0, 16383)) - 8192;
            stim_s[i] = int'($urandom_range(0, 16383)) - 8192;
        end
        clken = 1'b1;
        pulse_reset();
        for (int i = 0; i < NR; i++) begin
            if (i < NS) put(stim_v[i], stim_c[i], stim_s[i]);
            else put(1'b0, 0, 0);
            step();
            ref_snap[i] = snap();
        end
        pulse_reset();
        e = 0;
        c = 0;
        while (e < NR && c < 1000) begin
            clken = pat[c % 5][0];
            if (!clken) put(1'b1, int'($urandom_range(0, 16383)) - 8192,
                            int'($urandom_range(0, 16383)) - 8192);
            else if (e < NS) put(stim_v[e], stim_c[e], stim_s[e]);
            else put(1'b0, 0, 0);
            prev = snap();
            step();
            if (clken) begin
                chk_eq($sformatf("gate_seq%0d", e), snap(), ref_snap[e]);
                e++;
            end else begin
                chk_eq($sformatf("gate_hold%0d", c), snap(), prev);
            end
            c++;
        end
        chk_eq("gate_done", 64'(e), 64'(NR));
        clken = 1'b1;

        // Reset while 8 samples are in flight.
        for (int i = 0; i < 8; i++) begin
            put_phase(16'(i * 16'h1000));
            step();
        end
        put(1'b0, 0, 0);
        #2;
        reset_n = 1'b0;
        #1;
        chk_eq("mrst_outs", snap(), 64'd0);
        step();
        reset_n = 1'b1;
        stale = 1'b0;
        repeat (2 * LAT) begin
            step();
            stale |= out_valid;
        end
        chk_eq("mrst_stale", 64'(stale), 64'd0);
        run_point("mrst_first", 0, 8191, 16'h4000, 1'b0, 16'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
